alu_issue_unit: RTL

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

---
 rtl/alu_issue_unit_pkg.sv | 74 +++++++
 rtl/alu_issue_unit_alu_sel_decode.sv | 40 ++++
 rtl/alu_issue_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_unit_pkg.sv
// ============================================================================
// Module  : alu_issue_unit_pkg
// Purpose : Shared definitions for the ALU issue unit.
//           - `ALU_* opcode macros understood by the external ALU.
//           - `OPC_* operation-class encodings presented on op_class.
//           - FSM state type and the branch-condition helper.
//           This file is the project's single defines source and must be
//           compiled ahead of every file that uses the macros.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

`ifndef ALU_ISSUE_UNIT_DEFINES
`define ALU_ISSUE_UNIT_DEFINES

// External ALU opcodes (4 bits)
`define ALU_ADD   4'd0
`define ALU_SUB   4'd1
`define ALU_SLL   4'd2
`define ALU_SLT   4'd3
`define ALU_SLTU  4'd4
`define ALU_XOR   4'd5
`define ALU_SRL   4'd6
`define ALU_SRA   4'd7
`define ALU_OR    4'd8
`define ALU_AND   4'd9
`define ALU_PASS  4'd10

// Operation classes (3 bits)
`define OPC_OP      3'd0
`define OPC_OPIMM   3'd1
`define OPC_BRANCH  3'd2
`define OPC_JAL     3'd3
`define OPC_JALR    3'd4
`define OPC_LUI     3'd5
`define OPC_AUIPC   3'd6
`define OPC_ILLEGAL 3'd7

`endif

package alu_issue_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_TARGET = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Branch condition from the flags of rs1 - rs2. funct3 010/011 are not
    // valid branch encodings and are treated as never taken.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero,
                                          input logic       lt,
                                          input logic       ltu);
        logic taken;
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_unit_alu_sel_decode.sv
// ============================================================================
// Module  : alu_sel_decode
// Purpose : Combinational funct3/funct7b5 -> ALU opcode mapping for the
//           register (OP) and immediate (OPIMM) arithmetic classes.
// Ports   : i_is_opimm  - 1 when decoding an OPIMM instruction
//           i_funct3    - RV32I funct3
//           i_funct7b5  - instruction bit 30
//           o_alu_sel   - `ALU_* opcode
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_sel_decode (
    input  logic       i_is_opimm,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic [3:0] o_alu_sel
);

    always_comb begin
        o_alu_sel = `ALU_ADD;
        case (i_funct3)
            // Immediate forms have no subtract: bit 30 is part of the
            // immediate there, so it only selects SUB for register forms.
            3'b000:  o_alu_sel = (i_funct7b5 && !i_is_opimm) ? `ALU_SUB : `ALU_ADD;
            3'b001:  o_alu_sel = `ALU_SLL;
            3'b010:  o_alu_sel = `ALU_SLT;
            3'b011:  o_alu_sel = `ALU_SLTU;
            3'b100:  o_alu_sel = `ALU_XOR;
            3'b101:  o_alu_sel = i_funct7b5 ? `ALU_SRA : `ALU_SRL;
            3'b110:  o_alu_sel = `ALU_OR;
            3'b111:  o_alu_sel = `ALU_AND;
            default: o_alu_sel = `ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_unit.sv
// ============================================================================
// Module  : alu_issue_unit
// Purpose : Issues one RV32I integer/control operation at a time to an
//           external combinational ALU. EXEC computes the writeback value
//           and branch flags; control classes take an extra TARGET cycle to
//           form the redirect address on the same ALU.
// Ports   : clk, rst                  - clock, synchronous active-high reset
//           in_valid/in_ready          - operation handshake
//           op_class, funct3, funct7b5 - operation decode
//           rs1, rs2, imm, pc          - operands
//           alu_a, alu_b, alu_sel      - drive to external ALU
//           alu_out, alu_zero, alu_lt, alu_ltu - external ALU response
//           out_valid/out_ready        - result handshake
//           result, redirect, target   - writeback value and PC redirect
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_issue_unit
    import alu_issue_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op_class,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        alu_ltu,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        redirect,
    output logic [31:0] target
);

    state_t      r_state;
    state_t      w_state_next;

    logic [2:0]  r_op_class;
    logic [2:0]  r_funct3;
    logic        r_funct7b5;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [31:0] r_imm;
    logic [31:0] r_pc;

    logic        r_zero;
    logic        r_lt;
    logic        r_ltu;

    logic [31:0] r_result;
    logic        r_redirect;
    logic [31:0] r_target;

    logic        w_accept;
    logic        w_is_ctrl;
    logic        w_is_opimm;
    logic        w_has_result;
    logic        w_taken;
    logic [3:0]  w_dec_sel;

    assign w_accept     = in_valid && (r_state == S_IDLE);
    assign w_is_opimm   = (r_op_class == `OPC_OPIMM);
    assign w_is_ctrl    = (r_op_class == `OPC_BRANCH) || (r_op_class == `OPC_JAL) ||
                          (r_op_class == `OPC_JALR);
    assign w_has_result = (r_op_class != `OPC_BRANCH) && (r_op_class != `OPC_ILLEGAL);

    alu_sel_decode u_alu_sel_decode (
        .i_is_opimm (w_is_opimm),
        .i_funct3   (r_funct3),
        .i_funct7b5 (r_funct7b5),
        .o_alu_sel  (w_dec_sel)
    );

    // Jumps always redirect; branches use the flags captured during EXEC.
    always_comb begin
        w_taken = 1'b0;
        case (r_op_class)
            `OPC_JAL, `OPC_JALR: w_taken = 1'b1;
            `OPC_BRANCH:         w_taken = branch_taken(r_funct3, r_zero, r_lt, r_ltu);
            default:             w_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (in_valid)  w_state_next = S_EXEC;
            S_EXEC:   w_state_next = w_is_ctrl ? S_TARGET : S_DONE;
            S_TARGET: w_state_next = S_DONE;
            S_DONE:   if (out_ready) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU drive: idle values outside EXEC/TARGET
    // ------------------------------------------------------------------
    always_comb begin
        alu_a   = 32'd0;
        alu_b   = 32'd0;
        alu_sel = `ALU_PASS;
        case (r_state)
            S_EXEC: begin
                case (r_op_class)
                    `OPC_OP: begin
                        alu_a   = r_rs1;
                        alu_b   = r_rs2;
                        alu_sel = w_dec_sel;
                    end
                    `OPC_OPIMM: begin
                        alu_a   = r_rs1;
                        alu_b   = r_imm;
                        alu_sel = w_dec_sel;
                    end
                    `OPC_BRANCH: begin
                        alu_a   = r_rs1;
                        alu_b   = r_rs2;
                        alu_sel = `ALU_SUB;
                    end
                    `OPC_JAL, `OPC_JALR: begin
                        // Link address pc + 4
                        alu_a   = r_pc;
                        alu_b   = 32'd4;
                        alu_sel = `ALU_ADD;
                    end
                    `OPC_LUI: begin
                        alu_a   = r_imm;
                        alu_b   = 32'd0;
                        alu_sel = `ALU_PASS;
                    end
                    `OPC_AUIPC: begin
                        alu_a   = r_pc;
                        alu_b   = r_imm;
                        alu_sel = `ALU_ADD;
                    end
                    default: begin
                        alu_a   = 32'd0;
                        alu_b   = 32'd0;
                        alu_sel = `ALU_PASS;
                    end
                endcase
            end
            S_TARGET: begin
                alu_a   = (r_op_class == `OPC_JALR) ? r_rs1 : r_pc;
                alu_b   = r_imm;
                alu_sel = `ALU_ADD;
            end
            default: begin
                alu_a   = 32'd0;
                alu_b   = 32'd0;
                alu_sel = `ALU_PASS;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, operand capture and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op_class <= 3'd0;
            r_funct3   <= 3'd0;
            r_funct7b5 <= 1'b0;
            r_rs1      <= 32'd0;
            r_rs2      <= 32'd0;
            r_imm      <= 32'd0;
            r_pc       <= 32'd0;
            r_zero     <= 1'b0;
            r_lt       <= 1'b0;
            r_ltu      <= 1'b0;
            r_result   <= 32'd0;
            r_redirect <= 1'b0;
            r_target   <= 32'd0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_op_class <= op_class;
                r_funct3   <= funct3;
                r_funct7b5 <= funct7b5;
                r_rs1      <= rs1;
                r_rs2      <= rs2;
                r_imm      <= imm;
                r_pc       <= pc;
                r_result   <= 32'd0;
                r_redirect <= 1'b0;
                r_target   <= 32'd0;
            end

            if (r_state == S_EXEC) begin
                r_zero   <= alu_zero;
                r_lt     <= alu_lt;
                r_ltu    <= alu_ltu;
                r_result <= w_has_result ? alu_out : 32'd0;
            end

            // Target stays zero unless a redirect is actually taken.
            if (r_state == S_TARGET) begin
                r_redirect <= w_taken;
                if (!w_taken)
                    r_target <= 32'd0;
                else if (r_op_class == `OPC_JALR)
                    r_target <= alu_out & 32'hFFFF_FFFE;
                else
                    r_target <= alu_out;
            end

            // Clear on retirement so nothing stale is visible in IDLE.
            if ((r_state == S_DONE) && out_ready) begin
                r_result   <= 32'd0;
                r_redirect <= 1'b0;
                r_target   <= 32'd0;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign redirect  = r_redirect;
    assign target    = r_target;

endmodule

`default_nettype wire
